// File: rtl/wisc_pkg.sv
// wisc_pkg: shared word width, NOP encoding and fetch queue depth
package wisc_pkg;
    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] NOP_INSTR = 16'h0800;
    localparam int FQ_DEPTH = 4;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch/decode handshake bundle for the fetch queue
interface fetch_queue_if
    import wisc_pkg::*;
#(
    parameter int WIDTH = WORD_W
);
    logic             push;
    logic [WIDTH-1:0] instr_in;
    logic [WIDTH-1:0] pc2_in;
    logic             full;
    logic             pop;
    logic             valid_out;
    logic [WIDTH-1:0] instr_out;
    logic [WIDTH-1:0] pc2_out;
    logic             flush;
    logic             err;

    modport master (
        output push, instr_in, pc2_in, pop, flush,
        input  full, valid_out, instr_out, pc2_out, err
    );

    modport slave (
        input  push, instr_in, pc2_in, pop, flush,
        output full, valid_out, instr_out, pc2_out, err
    );
endinterface

// File: rtl/fq_storage.sv
// fq_storage: unreset entry array, one write port and one combinational read port
module fq_storage #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    // next array image: only the addressed slot changes on a write
    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    // contents survive reset and flush; only the pointers outside decide validity
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction/PC+2 buffer between fetch and decode, flushed on redirect
module fetch_queue
    import wisc_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    fetch_queue_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               err_q, err_d;
    logic               full, valid, do_push, do_pop;
    logic [2*WIDTH-1:0] rdata;

    assign full    = count_q == CW'(DEPTH);
    assign valid   = count_q != '0;
    assign do_push = bus.push & ~full & ~bus.flush;
    assign do_pop  = bus.pop & valid & ~bus.flush;

    // pointer/count advance; a flush squashes both sides and rewinds to empty
    always_comb begin
        rd_ptr_d = bus.flush ? '0 : rd_ptr_q + AW'(do_pop);
        wr_ptr_d = bus.flush ? '0 : wr_ptr_q + AW'(do_push);
        count_d  = bus.flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
        err_d    = ~bus.flush & ((bus.push & full) | (bus.pop & ~valid));
    end

    // state registers; reset beats flush, push and pop
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    fq_storage #(.DEPTH(DEPTH), .DW(2 * WIDTH)) u_storage (
        .clk   (clk),
        .we    (do_push),
        .waddr (wr_ptr_q),
        .wdata ({bus.instr_in, bus.pc2_in}),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign bus.full      = full;
    assign bus.valid_out = valid;
    assign bus.instr_out = valid ? rdata[2*WIDTH-1:WIDTH] : WIDTH'(NOP_INSTR);
    assign bus.pc2_out   = valid ? rdata[WIDTH-1:0] : '0;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed plan plus random traffic checked against a queue-based model
module tb_fetch_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic armed = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fetch_queue_if #(.WIDTH(16)) bus();
    fetch_queue dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] m_q[$];
    logic        m_err = 1'b0;

    task automatic lit(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference: FIFO of {instr,pc2}; decisions use occupancy before the edge
    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_err = 1'b0;
        end else begin
            automatic bit f = m_q.size() == 4;
            automatic bit v = m_q.size() != 0;
            m_err = !bus.flush && ((bus.push && f) || (bus.pop && !v));
            if (bus.flush) m_q.delete();
            else begin
                if (bus.pop && v) void'(m_q.pop_front());
                if (bus.push && !f) m_q.push_back({bus.instr_in, bus.pc2_in});
            end
        end
        armed <= 1'b1;
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (armed) begin
            automatic bit v = m_q.size() != 0;
            lit("valid_out", {15'b0, bus.valid_out}, {15'b0, v});
            lit("full", {15'b0, bus.full}, {15'b0, m_q.size() == 4});
            lit("err", {15'b0, bus.err}, {15'b0, m_err});
            lit("instr_out", bus.instr_out, v ? m_q[0][31:16] : 16'h0800);
            lit("pc2_out", bus.pc2_out, v ? m_q[0][15:0] : 16'h0000);
        end
    end

    task automatic cyc(input bit p, input logic [15:0] i, input logic [15:0] pc, input bit po, input bit fl);
        bus.push = p;
        bus.instr_in = i;
        bus.pc2_in = pc;
        bus.pop = po;
        bus.flush = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] fill_i [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        bus.push = 0; bus.instr_in = 0; bus.pc2_in = 0; bus.pop = 1; bus.flush = 0;
        rst = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        lit("rst_valid", {15'b0, bus.valid_out}, 16'h0);
        lit("rst_instr", bus.instr_out, 16'h0800);
        lit("rst_full", {15'b0, bus.full}, 16'h0);
        rst = 0;
        cyc(0, 0, 0, 1, 0);
        lit("empty_pop_err", {15'b0, bus.err}, 16'h1);
        cyc(0, 0, 0, 0, 0);
        lit("err_one_cycle", {15'b0, bus.err}, 16'h0);
        for (int k = 0; k < 4; k++) cyc(1, fill_i[k], 16'(2 * (k + 1)), 0, 0);
        lit("fill_full", {15'b0, bus.full}, 16'h1);
        cyc(1, 16'h5555, 16'h000A, 0, 0);
        lit("overflow_err", {15'b0, bus.err}, 16'h1);
        lit("overflow_full", {15'b0, bus.full}, 16'h1);
        for (int k = 0; k < 4; k++) begin
            lit("drain_instr", bus.instr_out, fill_i[k]);
            lit("drain_pc2", bus.pc2_out, 16'(2 * (k + 1)));
            cyc(0, 0, 0, 1, 0);
        end
        lit("drained_nop", bus.instr_out, 16'h0800);
        cyc(1, 16'h6000, 16'h0100, 0, 0);
        cyc(1, 16'h6001, 16'h0102, 0, 0);
        for (int k = 2; k < 12; k++) cyc(1, 16'(16'h6000 + k), 16'(16'h0100 + 2 * k), 1, 0);
        lit("wrap_head", bus.instr_out, 16'h600A);
        lit("wrap_err", {15'b0, bus.err}, 16'h0);
        cyc(1, 16'hE0E0, 16'h0200, 0, 0);
        cyc(1, 16'hAAAA, 16'h0202, 1, 1);
        lit("flush_valid", {15'b0, bus.valid_out}, 16'h0);
        lit("flush_instr", bus.instr_out, 16'h0800);
        lit("flush_full", {15'b0, bus.full}, 16'h0);
        lit("flush_err", {15'b0, bus.err}, 16'h0);
        cyc(1, 16'hBBBB, 16'h0300, 0, 0);
        lit("post_flush_head", bus.instr_out, 16'hBBBB);
        cyc(1, 16'hC1C1, 16'h0302, 0, 0);
        cyc(1, 16'hC2C2, 16'h0304, 0, 0);
        cyc(1, 16'hC3C3, 16'h0306, 0, 0);
        cyc(1, 16'hDDDD, 16'h0308, 1, 0);
        lit("fullpop_err", {15'b0, bus.err}, 16'h1);
        lit("fullpop_head", bus.instr_out, 16'hC1C1);
        lit("fullpop_full", {15'b0, bus.full}, 16'h0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 0);
        cyc(1, 16'h7777, 16'h0400, 0, 0);
        cyc(1, 16'h8888, 16'h0402, 0, 0);
        rst = 1;
        cyc(1, 16'h9999, 16'h0404, 1, 1);
        rst = 0;
        lit("midrst_valid", {15'b0, bus.valid_out}, 16'h0);
        lit("midrst_instr", bus.instr_out, 16'h0800);
        lit("midrst_pc2", bus.pc2_out, 16'h0000);
        lit("midrst_full", {15'b0, bus.full}, 16'h0);
        lit("midrst_err", {15'b0, bus.err}, 16'h0);
        for (int k = 0; k < 3000; k++) begin
            rst = $urandom_range(199) == 0;
            cyc($urandom_range(99) < 65, 16'($urandom), 16'($urandom),
                $urandom_range(99) < 55, $urandom_range(99) < 4);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Four-entry instruction buffer between the fetch stage (`infetch`) and decode. It decouples fetch from decode stalls. It captures each fetched instruction with its PC+2 and presents them in order to decode. It discards everything in flight when a branch or jump redirects the PC.

## Interface
Parameters:
- `DEPTH`, 4, number of entries; must be a power of two ≥ 2.
- `WIDTH`, 16, instruction and PC width.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `push` in 1: fetch presents a valid instruction this cycle.
- `instr_in` in WIDTH: fetched instruction.
- `pc2_in` in WIDTH: PC+2 of `instr_in`.
- `full` out 1: no free entry; fetch must hold its PC.
- `pop` in 1: decode consumes the head entry this cycle.
- `valid_out` out 1: a head entry exists.
- `instr_out` out WIDTH: head instruction, or NOP `16'h0800` when empty.
- `pc2_out` out WIDTH: head PC+2, or `16'h0000` when empty.
- `flush` in 1: a branch or jump was taken; discard all contents.
- `err` out 1: protocol violation pulse.

## Operation
- Circular buffer with read pointer `rd_ptr`, write pointer `wr_ptr` (each log2(DEPTH) bits, wrapping modulo DEPTH) and `count` (0..DEPTH).
- `full` = (`count` == DEPTH). `valid_out` = (`count` != 0). Both are decoded combinationally from registered `count`.
- Effective push: `push` & ~`full` & ~`flush`.
- Effective pop: `pop` & `valid_out` & ~`flush`.
- Push writes `instr_in` and `pc2_in` at `wr_ptr`, then increments `wr_ptr`.
- Pop increments `rd_ptr`.
- Count update:
  - push and pop together: `count` unchanged.
  - push only: `count` + 1.
  - pop only: `count` − 1.
- Push and pop in the same cycle at `count` == 1 or DEPTH−1 is legal. At `count` == DEPTH, push is refused even if a pop occurs. `full` is not bypassed by a same-cycle pop.
- Flush has highest priority. Next cycle: `rd_ptr` = `wr_ptr` = 0 and `count` = 0. A push in the flush cycle is dropped, because that instruction is on the wrong path. A pop in the flush cycle is ignored.
- `err` is asserted for exactly the following cycle when either:
  - `push` is high while `full` is high and `flush` is low (the instruction is dropped); or
  - `pop` is high while `valid_out` is low and `flush` is low.
- Storage contents are not cleared by reset or flush; only the pointers and count reset. Outputs are masked by `valid_out`.

## Timing
- Reset state:
  - `count` = 0, pointers = 0.
  - `valid_out` = 0, `full` = 0, `err` = 0.
  - `instr_out` = `16'h0800`, `pc2_out` = 0.
- Push-to-visible latency is 1 cycle. An entry pushed at edge N appears on `instr_out` after edge N; there is no same-cycle bypass when empty.
- Pop takes effect at the clock edge. The next entry, or NOP if the queue becomes empty, appears after that edge.
- Throughput: one push and one pop per cycle in steady state.
- Reset asserted mid-operation overrides flush, push and pop. The state returns to the reset state on the next edge.
- `err` is registered and follows the violation by 1 cycle.

## Structure
- Shared package `wisc_pkg`: `WORD_W` = 16, `NOP_INSTR` = `16'h0800`, `FQ_DEPTH` = 4.
- One natural sub-module, `fq_storage`: a DEPTH×(2·WIDTH) register array with one write port and one combinational read port. It has no reset.
- Pointers, count, the `full`/`valid_out` decode, output masking and `err` stay in `fetch_queue`.

## Test plan
- **Reset and empty:** assert `rst` for 2 cycles with `pop` = 1. Require `valid_out` = 0, `instr_out` = `16'h0800`, `full` = 0. After reset, `err` = 1 exactly one cycle after a pop with `valid_out` = 0.
- **Fill to full:** push `16'h1111`, `16'h2222`, `16'h3333`, `16'h4444` (PC+2 = 2, 4, 6, 8) with `pop` = 0.
  - `full` = 1 after the fourth edge.
  - A fifth push of `16'h5555` yields `err` = 1 for one cycle, and the queue still holds 4 entries.
  - Popping 4 times returns `1111`/2, `2222`/4, `3333`/6, `4444`/8 in order.
- **Wrap-around:** push and pop simultaneously every cycle for 10 cycles with `count` = 2. Require FIFO order preserved across pointer wrap, `count` steady at 2, and no `err`.
- **Flush priority:** with 3 entries, assert `flush` together with `push` (`16'hAAAA`) and `pop`.
  - Next cycle: `valid_out` = 0, `instr_out` = `16'h0800`, `full` = 0, `err` = 0.
  - A subsequent push of `16'hBBBB` appears at the head.
- **Full with pop:** at `count` = 4, drive `push` and `pop` together. The pop occurs and the push is refused (`err` = 1). Result: `count` = 3, with the head now the second-oldest entry.
- **Reset mid-operation:** with 2 entries and a flush pending, assert `rst`. Next cycle, all outputs are at their reset values.
